// File: rtl/result_deskew_collector_pkg.sv
// Shared defaults, collector state encoding and the aligned-row type.
package result_deskew_collector_pkg;

  localparam int N_COLS_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int IDX_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } coll_state_e;

  typedef logic signed [N_COLS_DEF-1:0][DATA_W_DEF-1:0] row_t;

endpackage

// File: rtl/result_deskew_collector_if.sv
// Column-input and row-output bundle of the deskew collector.
interface result_deskew_collector_if #(
  parameter int N_COLS = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
);
  logic                     start;
  logic [IDX_W-1:0]         num_rows;
  logic [N_COLS-1:0]        col_valid;
  logic [N_COLS*DATA_W-1:0] col_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_COLS*DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         out_row_idx;
  logic                     fifo_almost_full;
  logic                     overflow;
  logic                     skew_err;
  logic                     busy;
  logic                     done;

  modport master (
    output start, num_rows, col_valid, col_data, out_ready,
    input  out_valid, out_data, out_row_idx, fifo_almost_full,
           overflow, skew_err, busy, done
  );

  modport slave (
    input  start, num_rows, col_valid, col_data, out_ready,
    output out_valid, out_data, out_row_idx, fifo_almost_full,
           overflow, skew_err, busy, done
  );
endinterface

// File: rtl/result_deskew_collector_fifo.sv
// Generic single-clock FIFO; storage cleared on reset so the head reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so push is legal even when full.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/result_deskew_collector.sv
// Re-aligns skewed PE column results into rows and queues them for writeback.
// state   | meaning
// IDLE    | waiting for start
// COLLECT | counting aligned rows, writing full rows to the FIFO
// DRAIN   | all rows seen, waiting for the FIFO to empty
// DONE    | one-cycle completion pulse
module result_deskew_collector
  import result_deskew_collector_pkg::*;
#(
  parameter int N_COLS = N_COLS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input logic                      clk,
  input logic                      rst,
  result_deskew_collector_if.slave bus
);
  localparam int ROW_W  = N_COLS*DATA_W;
  localparam int WORD_W = ROW_W + IDX_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  coll_state_e                   state_q;
  logic [IDX_W-1:0]              rows_in_q, num_rows_q, rows_in_d;
  logic                          overflow_q, skew_err_q;
  logic                          flush;
  logic [N_COLS-1:0]             al_v;
  logic [N_COLS-1:0][DATA_W-1:0] al_d;
  logic                          full_row, skew_row, in_collect;
  logic                          fifo_full, fifo_empty, push, pop;
  logic [CNT_W-1:0]              fifo_count;
  logic [WORD_W-1:0]             wr_word, rd_word;

  assign flush = (state_q == S_IDLE) && bus.start && (bus.num_rows != '0);

  // Column c waits N_COLS-1-c cycles so every column lines up with the last one.
  for (genvar c = 0; c < N_COLS-1; c++) begin : g_dly
    localparam int STG = N_COLS-1-c;
    logic [STG-1:0]             v_q;
    logic [STG-1:0][DATA_W-1:0] d_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q[0] <= bus.col_valid[c];
        d_q[0] <= bus.col_data[c*DATA_W +: DATA_W];
        for (int s = 1; s < STG; s++) begin
          v_q[s] <= v_q[s-1];
          d_q[s] <= d_q[s-1];
        end
      end
    end

    assign al_v[c] = v_q[STG-1];
    assign al_d[c] = d_q[STG-1];
  end

  assign al_v[N_COLS-1] = bus.col_valid[N_COLS-1];
  assign al_d[N_COLS-1] = bus.col_data[(N_COLS-1)*DATA_W +: DATA_W];

  assign full_row   = &al_v;
  assign skew_row   = (|al_v) && !full_row;
  assign in_collect = (state_q == S_COLLECT);
  assign pop        = !fifo_empty && bus.out_ready;
  assign push       = in_collect && full_row && (!fifo_full || pop);
  assign wr_word    = {rows_in_q, al_d};
  assign rows_in_d  = rows_in_q + IDX_W'(1);

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (wr_word),
    .pop_i     (pop),
    .rd_data_o (rd_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rows_in_q  <= '0;
      num_rows_q <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            num_rows_q <= bus.num_rows;
            if (bus.num_rows == '0) begin
              state_q <= S_DONE;
            end else begin
              rows_in_q  <= '0;
              overflow_q <= 1'b0;
              skew_err_q <= 1'b0;
              state_q    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          // Dropped and skewed rows still use up an index, leaving a visible gap.
          if (full_row || skew_row) begin
            rows_in_q <= rows_in_d;
            if (rows_in_d == num_rows_q) state_q <= S_DRAIN;
            if (skew_row) skew_err_q <= 1'b1;
            if (full_row && fifo_full && !pop) overflow_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid        = !fifo_empty;
  assign bus.out_data         = rd_word[ROW_W-1:0];
  assign bus.out_row_idx      = rd_word[WORD_W-1 -: IDX_W];
  assign bus.fifo_almost_full = (fifo_count >= CNT_W'(DEPTH-1));
  assign bus.overflow         = overflow_q;
  assign bus.skew_err         = skew_err_q;
  assign bus.busy             = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign bus.done             = (state_q == S_DONE);
endmodule

// File: tb/tb_result_deskew_collector.sv
// Scoreboard bench for the deskew collector: rows queued when fed, compared when popped.
module tb_result_deskew_collector;
  import result_deskew_collector_pkg::*;

  localparam int N_COLS = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = 8;

  typedef struct {
    logic [IDX_W-1:0] idx;
    row_t             data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_deskew_collector_if #(.N_COLS(N_COLS), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  result_deskew_collector #(
    .N_COLS(N_COLS), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t              sb[$];
  exp_t              mon_e;
  row_t              rows[8];
  logic [N_COLS-1:0] vmask[8];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int feed_start = 0;
  int first_valid_cyc = -1;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic row_t mk_row(input int a0, input int a1, input int a2, input int a3);
    row_t r;
    r[0] = DATA_W'(a0);
    r[1] = DATA_W'(a1);
    r[2] = DATA_W'(a2);
    r[3] = DATA_W'(a3);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_row", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("row_idx", 64'(bus.out_row_idx), 64'(mon_e.idx));
        chk("row_data", bus.out_data, mon_e.data);
      end
    end
  end

  task automatic start_tile(input int n);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.num_rows = IDX_W'(n);
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // Row r, column c is driven in cycle r*gap + c; rows below n_store with a full mask are expected out.
  task automatic feed(input int nrows, input int gap, input int n_store);
    int last;
    last = (nrows-1)*gap + N_COLS-1;
    for (int r = 0; r < nrows; r++)
      if (r < n_store && (&vmask[r])) sb.push_back('{idx: IDX_W'(r), data: rows[r]});
    feed_start = cyc;
    for (int k = 0; k <= last; k++) begin
      logic [N_COLS-1:0]        v;
      logic [N_COLS*DATA_W-1:0] d;
      v = '0;
      d = '0;
      for (int c = 0; c < N_COLS; c++) begin
        int off;
        off = k - c;
        if (off >= 0 && (off % gap) == 0 && (off / gap) < nrows) begin
          v[c] = vmask[off/gap][c];
          d[c*DATA_W +: DATA_W] = rows[off/gap][c];
        end
      end
      bus.col_valid = v;
      bus.col_data  = d;
      @(posedge clk); #1;
    end
    bus.col_valid = '0;
    bus.col_data  = '0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("busy_at_done", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    bus.start     = 1'b0;
    bus.num_rows  = '0;
    bus.col_valid = '0;
    bus.col_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) vmask[i] = '1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_almost_full", 64'(bus.fifo_almost_full), 64'd0);
    chk("rst_flags", {62'd0, bus.overflow, bus.skew_err}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    #21 rst = 1'b0;

    // 1: basic flow with ready held high
    bus.out_ready = 1'b1;
    rows[0] = mk_row(10, -20, 0, -50);
    rows[1] = mk_row(5, -15, 100, 175);
    first_valid_cyc = -1;
    start_tile(2);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    feed(2, 1, 2);
    wait_done(20);
    chk("t1_latency", 64'(first_valid_cyc - feed_start), 64'(N_COLS));
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: backpressure fills the FIFO exactly
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rows[i] = mk_row(i*3+1, -(i+2), 1000*i, -(300+i));
    start_tile(4);
    feed(4, 1, 4);
    chk("t2_almost_full", 64'(bus.fifo_almost_full), 64'd1);
    chk("t2_overflow", 64'(bus.overflow), 64'd0);
    chk("t2_head_idx", 64'(bus.out_row_idx), 64'(sb[0].idx));
    repeat (3) @(negedge clk);
    chk("t2_head_hold_idx", 64'(bus.out_row_idx), 64'(sb[0].idx));
    chk("t2_head_hold_data", bus.out_data, sb[0].data);
    chk("t2_busy_drain", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(30);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: overflow drops rows 4 and 5
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) rows[i] = mk_row(-(i+1), 17*i, 32767-i, -32768+i);
    start_tile(6);
    feed(6, 1, 4);
    chk("t3_overflow", 64'(bus.overflow), 64'd1);
    chk("t3_skew", 64'(bus.skew_err), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(30);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // 4: row0 column 2 misses its slot
    bus.out_ready = 1'b1;
    rows[0] = mk_row(1, 2, 3, 4);
    rows[1] = mk_row(-7, -8, -9, -10);
    vmask[0] = 4'b1011;
    start_tile(2);
    feed(2, 1, 2);
    vmask[0] = '1;
    chk("t4_skew", 64'(bus.skew_err), 64'd1);
    chk("t4_overflow", 64'(bus.overflow), 64'd0);
    wait_done(20);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 6: empty tile
    start_tile(0);
    chk("t6_busy0", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("t6_done", 64'(bus.done), 64'd1);
    chk("t6_busy1", 64'(bus.busy), 64'd0);
    chk("t6_fifo", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("t6_done_once", 64'(bus.done), 64'd0);

    // 5: reset mid-collect aborts the tile
    bus.out_ready = 1'b0;
    rows[0] = mk_row(7, -1, 3, -32768);
    rows[1] = mk_row(9, 9, 9, 9);
    vmask[1] = 4'b1011;
    start_tile(3);
    feed(2, 1, 1);
    vmask[1] = '1;
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clk);
    chk("t5_stored", 64'(bus.out_valid), 64'd1);
    chk("t5_skew_before", 64'(bus.skew_err), 64'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_flags", {62'd0, bus.overflow, bus.skew_err}, 64'd0);
    sb.delete();
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt), 64'(dc));
    bus.out_ready = 1'b1;
    rows[0] = mk_row(-100, 200, -300, 400);
    start_tile(1);
    feed(1, 1, 1);
    wait_done(20);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
